conv_layer_sequencer: RTL and testbench

// - Layer-level scheduler for the 3-row convolve engine. Accepts one layer config
//   (stride, image height, kernel count, destination base).
// - Sequences row loads into the three line-buffer lanes (l1/l2/l3) and issues one

---
 rtl/conv_layer_sequencer_pkg.sv | 31 +++
 rtl/conv_layer_sequencer_lane_rotator.sv | 36 +++
 rtl/conv_layer_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_layer_sequencer_pkg
// Brief   : Shared types and constants for the convolution layer sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package conv_layer_sequencer_pkg;

    localparam logic [1:0] c_stride_1        = 2'd1;
    localparam logic [1:0] c_stride_2        = 2'd2;
    localparam int         c_dest_row_step   = 13;
    localparam int         c_preload_rows    = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRELOAD   = 3'd1,
        START     = 3'd2,
        WAIT_CONV = 3'd3,
        ADVANCE   = 3'd4,
        NEXT_K    = 3'd5
    } seq_state_t;

    // Lanes are 0..2 and steps 0..2, so a single conditional subtract is a full mod-3.
    function automatic logic [1:0] lane_add(input logic [1:0] lane, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, lane} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_sequencer_lane_rotator.sv
`default_nettype none
// ============================================================================
// Module  : lane_rotator
// Brief   : Mod-3 line-buffer lane counter with clear, increment and add-step.
// Revision: 1.0 - initial release
// ============================================================================
module lane_rotator
    import conv_layer_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_add_en,
    input  logic [1:0] i_add_val,
    output logic [1:0] o_lane
);

    logic [1:0] r_lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= 2'd0;
        end else if (i_clr) begin
            r_lane <= 2'd0;
        end else if (i_add_en) begin
            r_lane <= lane_add(r_lane, i_add_val);
        end else if (i_inc) begin
            r_lane <= lane_add(r_lane, 2'd1);
        end
    end

    assign o_lane = r_lane;

endmodule
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : conv_layer_sequencer
// Brief   : Layer scheduler: loads rows into three line-buffer lanes and issues
//           one convolve start per output row, looping over all kernels.
// Revision: 1.0 - initial release
// ============================================================================
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int MAX_H_W       = 6,
    parameter int KERN_W        = 4,
    parameter int DEST_W        = 5,
    parameter int DEST_ROW_STEP = c_dest_row_step
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_stride,
    input  logic [MAX_H_W-1:0] cfg_img_h,
    input  logic [KERN_W-1:0]  cfg_num_k,
    input  logic [DEST_W-1:0]  cfg_dest_base,
    output logic               cfg_err,
    input  logic               abort,
    output logic               row_req,
    output logic [MAX_H_W-1:0] row_addr,
    output logic [1:0]         row_lane,
    input  logic               row_ack,
    output logic               conv_start,
    output logic [1:0]         conv_stride,
    output logic [DEST_W-1:0]  conv_dest_addr,
    output logic [1:0]         conv_top_lane,
    input  logic               conv_done,
    output logic [KERN_W-1:0]  kernel_bank,
    output logic               busy,
    output logic               layer_done
);

    seq_state_t         r_state;
    logic [1:0]         r_stride;
    logic [KERN_W-1:0]  r_num_k;
    logic [KERN_W-1:0]  r_k;
    logic [DEST_W-1:0]  r_base;
    logic [DEST_W-1:0]  r_dest;
    logic [MAX_H_W-1:0] r_out_rows;
    logic [MAX_H_W-1:0] r_out_row;
    logic [MAX_H_W-1:0] r_next_row;
    logic [1:0]         r_adv_cnt;
    logic               r_row_req;
    logic               r_conv_start;
    logic               r_cfg_err;
    logic               r_layer_done;

    logic               w_cfg_legal;
    logic [MAX_H_W-1:0] w_span;
    logic [MAX_H_W-1:0] w_out_rows;
    logic [MAX_H_W-1:0] w_out_row_inc;
    logic               w_last_out_row;
    logic               w_accept;
    logic               w_ack;
    logic               w_done;
    logic               w_preload_last;
    logic               w_next_kernel;
    logic               w_wl_clr;
    logic               w_tl_clr;
    logic               w_tl_add;
    logic [1:0]         w_write_lane;
    logic [1:0]         w_top_lane;

    assign w_cfg_legal    = ((cfg_stride == c_stride_1) || (cfg_stride == c_stride_2))
                            && (cfg_img_h >= MAX_H_W'(c_preload_rows));
    assign w_span         = cfg_img_h - MAX_H_W'(c_preload_rows);
    assign w_out_rows     = ((cfg_stride == c_stride_2) ? (w_span >> 1) : w_span) + MAX_H_W'(1);
    assign w_out_row_inc  = r_out_row + MAX_H_W'(1);
    assign w_last_out_row = (w_out_row_inc == r_out_rows);

    // Qualified events: abort masks everything, and stray handshakes are dropped by state.
    assign w_accept       = (r_state == IDLE) && cfg_valid && w_cfg_legal && !abort;
    assign w_ack          = row_ack && ((r_state == PRELOAD) || (r_state == ADVANCE)) && !abort;
    assign w_done         = conv_done && (r_state == WAIT_CONV) && !abort;
    assign w_preload_last = w_ack && (r_state == PRELOAD) && (r_next_row == MAX_H_W'(2));
    assign w_next_kernel  = (r_state == NEXT_K) && (r_k != r_num_k) && !abort;

    assign w_wl_clr = w_accept || w_next_kernel;
    assign w_tl_clr = w_preload_last;
    assign w_tl_add = w_done && !w_last_out_row;

    lane_rotator u_write_lane (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_wl_clr),
        .i_inc     (w_ack),
        .i_add_en  (1'b0),
        .i_add_val (2'd0),
        .o_lane    (w_write_lane)
    );

    lane_rotator u_top_lane (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tl_clr),
        .i_inc     (1'b0),
        .i_add_en  (w_tl_add),
        .i_add_val (r_stride),
        .o_lane    (w_top_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stride     <= 2'd0;
            r_num_k      <= '0;
            r_k          <= '0;
            r_base       <= '0;
            r_dest       <= '0;
            r_out_rows   <= '0;
            r_out_row    <= '0;
            r_next_row   <= '0;
            r_adv_cnt    <= 2'd0;
            r_row_req    <= 1'b0;
            r_conv_start <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_layer_done <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_row_req <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cfg_valid) begin
                            if (!w_cfg_legal) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_stride   <= cfg_stride;
                                r_num_k    <= cfg_num_k;
                                r_base     <= cfg_dest_base;
                                r_dest     <= cfg_dest_base;
                                r_out_rows <= w_out_rows;
                                r_out_row  <= '0;
                                r_next_row <= '0;
                                r_k        <= '0;
                                r_adv_cnt  <= 2'd0;
                                r_row_req  <= 1'b1;
                                r_state    <= PRELOAD;
                            end
                        end
                    end
                    PRELOAD: begin
                        if (row_ack) begin
                            r_next_row <= r_next_row + MAX_H_W'(1);
                            if (w_preload_last) begin
                                r_row_req <= 1'b0;
                                r_state   <= START;
                            end
                        end
                    end
                    // Start is launched from here so an abort seen in START still cancels it.
                    START: begin
                        r_conv_start <= 1'b1;
                        r_state      <= WAIT_CONV;
                    end
                    WAIT_CONV: begin
                        if (conv_done) begin
                            r_out_row <= w_out_row_inc;
                            if (w_last_out_row) begin
                                r_state <= NEXT_K;
                            end else begin
                                r_dest    <= r_dest + DEST_W'(DEST_ROW_STEP);
                                r_row_req <= 1'b1;
                                r_state   <= ADVANCE;
                            end
                        end
                    end
                    ADVANCE: begin
                        if (row_ack) begin
                            r_next_row <= r_next_row + MAX_H_W'(1);
                            if ((r_adv_cnt + 2'd1) == r_stride) begin
                                r_adv_cnt <= 2'd0;
                                r_row_req <= 1'b0;
                                r_state   <= START;
                            end else begin
                                r_adv_cnt <= r_adv_cnt + 2'd1;
                            end
                        end
                    end
                    NEXT_K: begin
                        if (r_k == r_num_k) begin
                            r_layer_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_k        <= r_k + KERN_W'(1);
                            r_next_row <= '0;
                            r_out_row  <= '0;
                            r_dest     <= r_base;
                            r_row_req  <= 1'b1;
                            r_state    <= PRELOAD;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_row_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready      = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign cfg_err        = r_cfg_err;
    assign row_req        = r_row_req;
    assign row_addr       = r_next_row;
    assign row_lane       = w_write_lane;
    assign conv_start     = r_conv_start;
    assign conv_stride    = r_stride;
    assign conv_dest_addr = r_dest;
    assign conv_top_lane  = w_top_lane;
    assign kernel_bank    = r_k;
    assign layer_done     = r_layer_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_layer_sequencer
// Brief   : Self-checking bench; acts as row loader and convolve engine and
//           compares observed events with an event-list model of the layer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_layer_sequencer;

    localparam int MAX_H_W = 6;
    localparam int KERN_W  = 4;
    localparam int DEST_W  = 5;
    localparam int STEP    = 13;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_stride;
    logic [MAX_H_W-1:0] cfg_img_h;
    logic [KERN_W-1:0]  cfg_num_k;
    logic [DEST_W-1:0]  cfg_dest_base;
    logic               cfg_err;
    logic               abort;
    logic               row_req;
    logic [MAX_H_W-1:0] row_addr;
    logic [1:0]         row_lane;
    logic               row_ack;
    logic               conv_start;
    logic [1:0]         conv_stride;
    logic [DEST_W-1:0]  conv_dest_addr;
    logic [1:0]         conv_top_lane;
    logic               conv_done;
    logic [KERN_W-1:0]  kernel_bank;
    logic               busy;
    logic               layer_done;

    conv_layer_sequencer #(
        .MAX_H_W(MAX_H_W), .KERN_W(KERN_W), .DEST_W(DEST_W), .DEST_ROW_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stride(cfg_stride),
        .cfg_img_h(cfg_img_h), .cfg_num_k(cfg_num_k), .cfg_dest_base(cfg_dest_base),
        .cfg_err(cfg_err), .abort(abort),
        .row_req(row_req), .row_addr(row_addr), .row_lane(row_lane), .row_ack(row_ack),
        .conv_start(conv_start), .conv_stride(conv_stride), .conv_dest_addr(conv_dest_addr),
        .conv_top_lane(conv_top_lane), .conv_done(conv_done),
        .kernel_bank(kernel_bank), .busy(busy), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 row load, 1 conv start, 2 layer done
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    ev_t q[$];
    int  obs_row[$], obs_lane[$], obs_dest[$], obs_top[$], obs_bank[$];
    int  obs_done;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  exp_stride = 0;
    int  spur_en = 0;
    int  ack_dly = 0;
    int  conv_dly = 0;
    int  conv_pend = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int got_at(input int qq[$], input int i);
        return (i < qq.size()) ? qq[i] : -1;
    endfunction

    // Model: window j covers rows j*s..j*s+2; row r lives in lane r%3.
    task automatic push_layer(input int h, input int s, input int nk, input int base);
        int out_rows;
        out_rows   = (h - 3) / s + 1;
        exp_stride = s;
        for (int k = 0; k <= nk; k++) begin
            for (int r = 0; r < 3; r++) q.push_back('{0, r, r % 3, 0, 0});
            for (int j = 0; j < out_rows; j++) begin
                if (j > 0)
                    for (int r = (j - 1) * s + 3; r <= j * s + 2; r++)
                        q.push_back('{0, r, r % 3, 0, 0});
                q.push_back('{1, (base + STEP * j) % 32, (j * s) % 3, s, k});
            end
        end
        q.push_back('{2, 0, 0, 0, 0});
    endtask

    task automatic match(input ev_t got);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d with no event required", got.kind);
            return;
        end
        e = q.pop_front();
        check("event_kind", got.kind, e.kind);
        if (got.kind == e.kind && e.kind == 0) begin
            check("row_addr", got.a, e.a);
            check("row_lane", got.b, e.b);
        end else if (got.kind == e.kind && e.kind == 1) begin
            check("conv_dest_addr", got.a, e.a);
            check("conv_top_lane", got.b, e.b);
            check("conv_stride", got.c, e.c);
            check("kernel_bank", got.d, e.d);
        end
    endtask

    // One cycle: sample at the falling edge, compare, then drive responder inputs.
    task automatic tick();
        @(negedge clk);
        if (busy) check("stride_stable", int'(conv_stride), exp_stride);
        if (layer_done) begin
            obs_done++;
            check("done_not_busy", int'(busy), 0);
            match('{2, 0, 0, 0, 0});
        end
        if (conv_start) begin
            obs_dest.push_back(int'(conv_dest_addr));
            obs_top.push_back(int'(conv_top_lane));
            obs_bank.push_back(int'(kernel_bank));
            match('{1, int'(conv_dest_addr), int'(conv_top_lane), int'(conv_stride), int'(kernel_bank)});
            conv_pend = 1;
            conv_dly  = $urandom_range(0, 3);
        end
        if (row_ack) row_ack = 1'b0;
        else if (row_req) begin
            if (ack_dly == 0) begin
                obs_row.push_back(int'(row_addr));
                obs_lane.push_back(int'(row_lane));
                match('{0, int'(row_addr), int'(row_lane), 0, 0});
                row_ack = 1'b1;
                ack_dly = $urandom_range(0, 3);
            end else ack_dly--;
        end else if (spur_en != 0 && $urandom_range(0, 5) == 0) row_ack = 1'b1;
        if (conv_done) conv_done = 1'b0;
        else if (conv_pend != 0) begin
            if (conv_dly == 0) begin
                conv_done = 1'b1;
                conv_pend = 0;
            end else conv_dly--;
        end else if (spur_en != 0 && $urandom_range(0, 5) == 0) conv_done = 1'b1;
    endtask

    task automatic clear_obs();
        obs_row.delete(); obs_lane.delete(); obs_dest.delete();
        obs_top.delete(); obs_bank.delete(); obs_done = 0;
    endtask

    task automatic start_layer(input int h, input int s, input int nk, input int base);
        clear_obs();
        push_layer(h, s, nk, base);
        cfg_stride    = 2'(s);
        cfg_img_h     = MAX_H_W'(h);
        cfg_num_k     = KERN_W'(nk);
        cfg_dest_base = DEST_W'(base);
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("accept_busy", int'(busy), 1);
        check("accept_row_req", int'(row_req), 1);
    endtask

    task automatic run_layer(input int h, input int s, input int nk, input int base, input int spur);
        int t;
        spur_en = spur;
        start_layer(h, s, nk, base);
        t = 0;
        while ((q.size() != 0 || busy) && t < 5000) begin
            tick();
            t++;
        end
        if (t >= 5000) begin
            n_checks++;
            $display("FAIL layer_timeout: %0d events outstanding after %0d cycles", q.size(), t);
            q.delete();
        end
        spur_en = 0;
        tick();
        tick();
        check("layer_done_count", obs_done, 1);
    endtask

    task automatic cfg_reject(input int s, input int h);
        cfg_stride = 2'(s);
        cfg_img_h  = MAX_H_W'(h);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("reject_err_pulse", int'(cfg_err), 1);
        check("reject_not_busy", int'(busy), 0);
        tick();
        check("reject_err_low", int'(cfg_err), 0);
        check("reject_still_idle", int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [25:0] v;
        v = {row_req, row_addr, row_lane, conv_start, conv_stride, conv_dest_addr,
             conv_top_lane, kernel_bank, busy, layer_done, cfg_err};
        check({name, "_outputs_zero"}, int'(v), 0);
        check({name, "_cfg_ready"}, int'(cfg_ready), 1);
    endtask

    initial begin
        int t;
        rst = 1'b1; cfg_valid = 1'b0; cfg_stride = 2'd0; cfg_img_h = '0;
        cfg_num_k = '0; cfg_dest_base = '0; abort = 1'b0; row_ack = 1'b0; conv_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // H=5, s=1, one kernel, base 2
        run_layer(5, 1, 0, 2, 0);
        check("t1_nrows", obs_row.size(), 5);
        check("t1_row4", got_at(obs_row, 4), 4);
        check("t1_lane3", got_at(obs_lane, 3), 0);
        check("t1_lane4", got_at(obs_lane, 4), 1);
        check("t1_nconv", obs_dest.size(), 3);
        check("t1_dest0", got_at(obs_dest, 0), 2);
        check("t1_dest1", got_at(obs_dest, 1), 15);
        check("t1_dest2", got_at(obs_dest, 2), 28);
        check("t1_top1", got_at(obs_top, 1), 1);
        check("t1_top2", got_at(obs_top, 2), 2);

        // H=7, s=2
        run_layer(7, 2, 0, 9, 0);
        check("t2_nconv", obs_dest.size(), 3);
        check("t2_row3", got_at(obs_row, 3), 3);
        check("t2_row6", got_at(obs_row, 6), 6);
        check("t2_top1", got_at(obs_top, 1), 2);
        check("t2_top2", got_at(obs_top, 2), 1);

        // Illegal configurations
        cfg_reject(3, 10);
        cfg_reject(0, 10);
        cfg_reject(1, 2);

        // Two kernels, minimal height
        run_layer(3, 1, 1, 30, 0);
        check("t4_nconv", obs_bank.size(), 2);
        check("t4_bank0", got_at(obs_bank, 0), 0);
        check("t4_bank1", got_at(obs_bank, 1), 1);
        check("t4_nrows", obs_row.size(), 6);
        check("t4_row3", got_at(obs_row, 3), 0);

        // Stray handshakes outside their states
        run_layer(9, 1, 1, 5, 1);
        run_layer(11, 2, 2, 17, 1);

        // Randomized layers
        for (int i = 0; i < 10; i++)
            run_layer($urandom_range(3, 20), $urandom_range(1, 2), $urandom_range(0, 3),
                      $urandom_range(0, 31), $urandom_range(0, 1));

        // Abort while in START: the pending conv_start must never appear
        start_layer(5, 1, 0, 7);
        t = 0;
        while (obs_row.size() < 3 && t < 200) begin tick(); t++; end
        tick();
        abort = 1'b1;
        q.delete();
        tick();
        abort = 1'b0;
        check("abort_no_start", int'(conv_start), 0);
        check("abort_idle", int'(busy), 0);
        check("abort_row_req", int'(row_req), 0);
        repeat (6) tick();
        check("abort_no_start_later", obs_dest.size(), 0);

        // Asynchronous reset while waiting for the engine
        start_layer(5, 1, 0, 4);
        t = 0;
        while (obs_dest.size() < 1 && t < 200) begin tick(); t++; end
        check("rst_reached_wait", obs_dest.size(), 1);
        rst = 1'b1;
        q.delete();
        row_ack = 1'b0; conv_done = 1'b0; conv_pend = 0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("after_rst");
        check("after_rst_no_done", obs_done, 0);

        run_layer(6, 2, 1, 11, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
